regfile_sequencer: RTL and testbench

Instruction-driven initiator for the 4-entry × 32-bit register file: the requester side of its RegWrite/ReadReg/WriteReg/WriteData port. Accepts one 32-bit instruction at a time over a valid/ready handshake and issues a read cycle. It then computes the result from the register file's registered read data and issues a single write-back cycle. It sits between the instruction source (testbench or fetch logic) and the register file.

---
 rtl/regfile_sequencer_if.sv | 26 ++
 rtl/regfile_sequencer.sv | 148 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Instruction-source and register-file signals between regfile_sequencer and its neighbours.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface regfile_sequencer_if;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic        InstrReady;
    logic        RegWrite;
    logic [1:0]  ReadReg1;
    logic [1:0]  ReadReg2;
    logic [1:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Done;
    logic        Error;

    modport master (
        input  InstrValid, Instruction, ReadData1, ReadData2,
        output InstrReady, RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Done, Error
    );

    modport slave (
        output InstrValid, Instruction, ReadData1, ReadData2,
        input  InstrReady, RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Done, Error
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Register-file initiator: one instruction at a time, READ/EXEC/WRITE, Done 4 cycles after accept.
// InstrReady is high only in IDLE; NOP and illegal opcodes retire in 1 cycle and keep it high.
module regfile_sequencer (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_LUI  = 4'h8;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  rd_q, rd_d;
    logic [15:0] imm_q, imm_d;
    logic        instr_ready_q, instr_ready_d;
    logic        reg_write_q, reg_write_d;
    logic [1:0]  read_reg1_q, read_reg1_d;
    logic [1:0]  read_reg2_q, read_reg2_d;
    logic [1:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [3:0]  op_in;
    logic [31:0] alu_result;
    logic        unused_instr_bits;

    assign op_in             = bus.Instruction[31:28];
    assign unused_instr_bits = ^bus.Instruction[21:16];

    always_comb begin
        alu_result = 32'h0;
        case (op_q)
            OP_ADD:  alu_result = bus.ReadData1 + bus.ReadData2;
            OP_SUB:  alu_result = bus.ReadData1 - bus.ReadData2;
            OP_AND:  alu_result = bus.ReadData1 & bus.ReadData2;
            OP_OR:   alu_result = bus.ReadData1 | bus.ReadData2;
            OP_XOR:  alu_result = bus.ReadData1 ^ bus.ReadData2;
            OP_ADDI: alu_result = bus.ReadData1 + {{16{imm_q[15]}}, imm_q};
            OP_SLT:  alu_result = {31'h0, ($signed(bus.ReadData1) < $signed(bus.ReadData2))};
            OP_LUI:  alu_result = {imm_q, 16'h0};
            default: alu_result = 32'h0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        instr_ready_d = 1'b0;
        reg_write_d   = 1'b0;
        read_reg1_d   = read_reg1_q;
        read_reg2_d   = read_reg2_q;
        write_reg_d   = write_reg_q;
        write_data_d  = write_data_q;
        done_d        = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready_d = 1'b1;
                if (bus.InstrValid) begin
                    // NOP and illegal opcodes retire here without touching any register-file port.
                    if (op_in > OP_LUI) begin
                        error_d = 1'b1;
                    end else if (op_in == OP_NOP) begin
                        done_d = 1'b1;
                    end else begin
                        op_d          = op_in;
                        rd_d          = bus.Instruction[27:26];
                        imm_d         = bus.Instruction[15:0];
                        read_reg1_d   = bus.Instruction[25:24];
                        read_reg2_d   = bus.Instruction[23:22];
                        instr_ready_d = 1'b0;
                        state_d       = READ;
                    end
                end
            end
            READ: begin
                state_d = EXEC;
            end
            EXEC: begin
                write_data_d = alu_result;
                write_reg_d  = rd_q;
                reg_write_d  = 1'b1;
                state_d      = WRITE;
            end
            WRITE: begin
                done_d        = 1'b1;
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            op_q          <= 4'h0;
            rd_q          <= 2'h0;
            imm_q         <= 16'h0;
            instr_ready_q <= 1'b1;
            reg_write_q   <= 1'b0;
            read_reg1_q   <= 2'h0;
            read_reg2_q   <= 2'h0;
            write_reg_q   <= 2'h0;
            write_data_q  <= 32'h0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            instr_ready_q <= instr_ready_d;
            reg_write_q   <= reg_write_d;
            read_reg1_q   <= read_reg1_d;
            read_reg2_q   <= read_reg2_d;
            write_reg_q   <= write_reg_d;
            write_data_q  <= write_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.InstrReady = instr_ready_q;
    assign bus.RegWrite   = reg_write_q;
    assign bus.ReadReg1   = read_reg1_q;
    assign bus.ReadReg2   = read_reg2_q;
    assign bus.WriteReg   = write_reg_q;
    assign bus.WriteData  = write_data_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a 4x32 register file that registers its read data.
module tb_regfile_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic rf_clear;
    logic [31:0] regs [4];
    logic [31:0] rd1_q, rd2_q;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sequencer_if rf_if();

    regfile_sequencer dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (rf_if.master)
    );

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
        end else if (rf_if.RegWrite) begin
            regs[rf_if.WriteReg] <= rf_if.WriteData;
        end
        rd1_q <= regs[rf_if.ReadReg1];
        rd2_q <= regs[rf_if.ReadReg2];
    end

    assign rf_if.ReadData1 = rd1_q;
    assign rf_if.ReadData2 = rd2_q;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [15:0] imm);
        return {op, rd, rs, rt, 6'b0, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge in an IDLE cycle; leaves just after the negedge of the Done cycle.
    task automatic run_alu(input string name, input logic [31:0] ins, input logic [31:0] exp);
        rf_if.Instruction = ins;
        rf_if.InstrValid  = 1'b1;
        @(posedge clk);
        #1 rf_if.InstrValid = 1'b0;
        @(negedge clk);
        chk({name, ":c1_ready"}, 32'(rf_if.InstrReady), 32'd0);
        chk({name, ":c1_regwrite"}, 32'(rf_if.RegWrite), 32'd0);
        chk({name, ":c1_readreg1"}, 32'(rf_if.ReadReg1), 32'(ins[25:24]));
        chk({name, ":c1_readreg2"}, 32'(rf_if.ReadReg2), 32'(ins[23:22]));
        @(negedge clk);
        chk({name, ":c2_regwrite"}, 32'(rf_if.RegWrite), 32'd0);
        chk({name, ":c2_ready"}, 32'(rf_if.InstrReady), 32'd0);
        @(negedge clk);
        chk({name, ":c3_regwrite"}, 32'(rf_if.RegWrite), 32'd1);
        chk({name, ":c3_writereg"}, 32'(rf_if.WriteReg), 32'(ins[27:26]));
        chk({name, ":c3_writedata"}, rf_if.WriteData, exp);
        chk({name, ":c3_done"}, 32'(rf_if.Done), 32'd0);
        @(negedge clk);
        chk({name, ":c4_done"}, 32'(rf_if.Done), 32'd1);
        chk({name, ":c4_error"}, 32'(rf_if.Error), 32'd0);
        chk({name, ":c4_ready"}, 32'(rf_if.InstrReady), 32'd1);
        chk({name, ":c4_regwrite"}, 32'(rf_if.RegWrite), 32'd0);
        chk({name, ":c4_regfile"}, regs[ins[27:26]], exp);
    endtask

    logic [31:0] stream [3];
    int k, dn, rw, cyc;

    initial begin
        rst_n             = 1'b0;
        rf_clear          = 1'b1;
        rf_if.InstrValid  = 1'b0;
        rf_if.Instruction = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rf_if.InstrReady), 32'd1);
        chk("rst_regwrite", 32'(rf_if.RegWrite), 32'd0);
        chk("rst_readreg1", 32'(rf_if.ReadReg1), 32'd0);
        chk("rst_readreg2", 32'(rf_if.ReadReg2), 32'd0);
        chk("rst_writereg", 32'(rf_if.WriteReg), 32'd0);
        chk("rst_writedata", rf_if.WriteData, 32'd0);
        chk("rst_done", 32'(rf_if.Done), 32'd0);
        chk("rst_error", 32'(rf_if.Error), 32'd0);
        rst_n    = 1'b1;
        rf_clear = 1'b0;

        run_alu("lui_r1",   enc(4'h8, 2'd1, 2'd0, 2'd0, 16'h1234), 32'h12340000);
        run_alu("addi_r1",  enc(4'h6, 2'd1, 2'd1, 2'd0, 16'h5678), 32'h12345678);
        run_alu("addi_r2",  enc(4'h6, 2'd2, 2'd0, 2'd0, 16'hFFFF), 32'hFFFFFFFF);
        run_alu("add_wrap", enc(4'h1, 2'd3, 2'd2, 2'd2, 16'h0),    32'hFFFFFFFE);
        run_alu("addi_r0",  enc(4'h6, 2'd0, 2'd0, 2'd0, 16'hFFFF), 32'hFFFFFFFF);
        run_alu("sub_wrap", enc(4'h2, 2'd1, 2'd0, 2'd2, 16'h0),    32'h00000000);
        run_alu("lui_min",  enc(4'h8, 2'd1, 2'd0, 2'd0, 16'h8000), 32'h80000000);
        run_alu("xor_zero", enc(4'h5, 2'd2, 2'd2, 2'd2, 16'h0),    32'h00000000);
        run_alu("addi_one", enc(4'h6, 2'd2, 2'd2, 2'd0, 16'h0001), 32'h00000001);
        run_alu("slt_true", enc(4'h7, 2'd3, 2'd1, 2'd2, 16'h0),    32'h00000001);
        run_alu("slt_false",enc(4'h7, 2'd3, 2'd2, 2'd1, 16'h0),    32'h00000000);
        run_alu("or",       enc(4'h4, 2'd3, 2'd1, 2'd2, 16'h0),    32'h80000001);
        run_alu("and",      enc(4'h3, 2'd3, 2'd0, 2'd1, 16'h0),    32'h80000000);

        // Illegal opcode followed back-to-back by a NOP.
        rf_if.Instruction = enc(4'hF, 2'd3, 2'd1, 2'd2, 16'h0);
        rf_if.InstrValid  = 1'b1;
        @(posedge clk);
        #1 rf_if.Instruction = 32'h0;
        @(negedge clk);
        chk("ill_error", 32'(rf_if.Error), 32'd1);
        chk("ill_done", 32'(rf_if.Done), 32'd0);
        chk("ill_ready", 32'(rf_if.InstrReady), 32'd1);
        chk("ill_regwrite", 32'(rf_if.RegWrite), 32'd0);
        @(posedge clk);
        #1 rf_if.InstrValid = 1'b0;
        @(negedge clk);
        chk("nop_done", 32'(rf_if.Done), 32'd1);
        chk("nop_error", 32'(rf_if.Error), 32'd0);
        chk("nop_ready", 32'(rf_if.InstrReady), 32'd1);
        chk("nop_regwrite", 32'(rf_if.RegWrite), 32'd0);
        @(negedge clk);
        chk("nop_done_clear", 32'(rf_if.Done), 32'd0);
        chk("ill_r3_kept", regs[3], 32'h80000000);

        // Reset asserted during WRITE aborts the write-back.
        rf_if.Instruction = enc(4'h1, 2'd3, 2'd0, 2'd0, 16'h0);
        rf_if.InstrValid  = 1'b1;
        @(posedge clk);
        #1 rf_if.InstrValid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_write_regwrite", 32'(rf_if.RegWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_regwrite", 32'(rf_if.RegWrite), 32'd0);
        chk("mid_rst_writedata", rf_if.WriteData, 32'd0);
        chk("mid_rst_ready", 32'(rf_if.InstrReady), 32'd1);
        @(negedge clk);
        chk("mid_rst_done", 32'(rf_if.Done), 32'd0);
        chk("mid_rst_r3_kept", regs[3], 32'h80000000);
        rst_n = 1'b1;
        run_alu("post_rst_xor", enc(4'h5, 2'd3, 2'd3, 2'd1, 16'h0), 32'h00000000);

        // InstrValid held high across three ALU instructions.
        stream[0] = enc(4'h1, 2'd3, 2'd1, 2'd2, 16'h0);
        stream[1] = enc(4'h2, 2'd2, 2'd3, 2'd0, 16'h0);
        stream[2] = enc(4'h5, 2'd1, 2'd2, 2'd3, 16'h0);
        k = 0; dn = 0; rw = 0; cyc = 0;
        while (dn < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rf_if.Done)     dn++;
            if (rf_if.RegWrite) rw++;
            if (rf_if.InstrReady) begin
                if (k < 3) begin
                    rf_if.Instruction = stream[k];
                    rf_if.InstrValid  = 1'b1;
                    k++;
                end else begin
                    rf_if.InstrValid = 1'b0;
                end
            end
        end
        rf_if.InstrValid = 1'b0;
        chk("stream_done_count", 32'(dn), 32'd3);
        chk("stream_regwrite_count", 32'(rw), 32'd3);
        chk("stream_cycles", 32'(cyc), 32'd13);
        chk("stream_r0", regs[0], 32'hFFFFFFFF);
        chk("stream_r1", regs[1], 32'h00000003);
        chk("stream_r2", regs[2], 32'h80000002);
        chk("stream_r3", regs[3], 32'h80000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
